// File: rtl/pattern_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_serializer
//  Description : Parallel-to-serial feeder for the serial pattern detector.
//                Accepts WIDTH-bit words over a valid/ready handshake and
//                shifts them out one bit per clock on a registered serial
//                line. A one-entry holding buffer lets consecutive words
//                stream with no idle gap. The line rests at IDLE_BIT when
//                no word is in flight.
//  Ports       : clk          rising-edge clock
//                rst_n        synchronous active-low reset
//                din          parallel word, taken when din_valid && din_ready
//                din_valid    upstream has a word
//                din_ready    a word can be accepted this cycle
//                sout         registered serial bit
//                sout_valid   sout carries a data bit
//                frame_start  pulse with the first bit of each word
//                word_cnt     words fully shifted out (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic [15:0]      word_cnt
);

  localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_v_q, hold_v_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             frame_start_q, frame_start_d;
  logic [15:0]      word_cnt_q, word_cnt_d;

  logic             w_accept;
  logic [WIDTH-1:0] w_sr_shifted;

  // Bit that leaves first from a freshly loaded word.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // The bit currently on sout is dropped so the next one sits in the
  // position first_bit() reads.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign din_ready    = rst_n && !hold_v_q;
  assign w_accept     = din_valid && din_ready;
  assign w_sr_shifted = shift_word(sr_q);

  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    cnt_d         = cnt_q;
    hold_d        = hold_q;
    hold_v_d      = hold_v_q;
    sout_d        = sout_q;
    sout_valid_d  = sout_valid_q;
    frame_start_d = 1'b0;
    word_cnt_d    = word_cnt_q;

    case (state_q)
      S_IDLE: begin
        sout_d       = IDLE_BIT;
        sout_valid_d = 1'b0;
        if (w_accept) begin
          sr_d          = din;
          cnt_d         = '0;
          sout_d        = first_bit(din);
          sout_valid_d  = 1'b1;
          frame_start_d = 1'b1;
          state_d       = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (cnt_q == LAST_IDX) begin
          // The last bit of the current word leaves at this edge.
          word_cnt_d = word_cnt_q + 16'd1;
          cnt_d      = '0;
          if (hold_v_q) begin
            sr_d          = hold_q;
            hold_v_d      = 1'b0;
            sout_d        = first_bit(hold_q);
            sout_valid_d  = 1'b1;
            frame_start_d = 1'b1;
          end else if (w_accept) begin
            // Holding buffer empty: a word arriving right now bypasses it.
            sr_d          = din;
            sout_d        = first_bit(din);
            sout_valid_d  = 1'b1;
            frame_start_d = 1'b1;
          end else begin
            sout_d       = IDLE_BIT;
            sout_valid_d = 1'b0;
            state_d      = S_IDLE;
          end
        end else begin
          cnt_d        = cnt_q + CNT_W'(1);
          sr_d         = w_sr_shifted;
          sout_d       = first_bit(w_sr_shifted);
          sout_valid_d = 1'b1;
          if (w_accept) begin
            hold_d   = din;
            hold_v_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sr_q          <= '0;
      cnt_q         <= '0;
      hold_q        <= '0;
      hold_v_q      <= 1'b0;
      sout_q        <= IDLE_BIT;
      sout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      word_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      hold_v_q      <= hold_v_d;
      sout_q        <= sout_d;
      sout_valid_q  <= sout_valid_d;
      frame_start_q <= frame_start_d;
      word_cnt_q    <= word_cnt_d;
    end
  end

  assign sout        = sout_q;
  assign sout_valid  = sout_valid_q;
  assign frame_start = frame_start_q;
  assign word_cnt    = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pattern_serializer
//  Description : Directed self-checking bench for pattern_serializer. One
//                MSB-first instance and one LSB-first instance, both
//                WIDTH=8, IDLE_BIT=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_serializer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  din0, din1;
  logic        din_valid0, din_valid1;
  logic        din_ready0, din_ready1;
  logic        sout0, sout1;
  logic        sout_valid0, sout_valid1;
  logic        frame_start0, frame_start1;
  logic [15:0] word_cnt0, word_cnt1;

  int tests_run;
  int tests_failed;

  pattern_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .din(din0), .din_valid(din_valid0),
    .din_ready(din_ready0), .sout(sout0), .sout_valid(sout_valid0),
    .frame_start(frame_start0), .word_cnt(word_cnt0)
  );

  pattern_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .din_valid(din_valid1),
    .din_ready(din_ready1), .sout(sout1), .sout_valid(sout_valid1),
    .frame_start(frame_start1), .word_cnt(word_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are then inspected 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    din_valid0 = 1'b0;
    din_valid1 = 1'b0;
    din0       = 8'h00;
    din1       = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    din_valid0 = 1'b0;
    din_valid1 = 1'b0;
    tick();
    tick();
    tests_run++;
    if (sout0 !== 1'b1 || sout_valid0 !== 1'b0 || frame_start0 !== 1'b0 ||
        word_cnt0 !== 16'h0000 || din_ready0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: sout=%b sv=%b fs=%b cnt=%h rdy=%b expected 1 0 0 0000 0",
               sout0, sout_valid0, frame_start0, word_cnt0, din_ready0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests_run++;
      if (sout0 !== 1'b1 || sout_valid0 !== 1'b0 || din_ready0 !== 1'b1 ||
          word_cnt0 !== 16'h0000) begin
        tests_failed++;
        $display("FAIL idle_cycle%0d: sout=%b sv=%b rdy=%b cnt=%h expected 1 0 1 0000",
                 i, sout0, sout_valid0, din_ready0, word_cnt0);
      end
    end
  endtask

  task automatic test_single_word();
    logic [7:0] exp_bits;
    exp_bits = 8'b0100_1010;  // 0x4A, MSB first
    apply_reset();
    din0       = 8'h4A;
    din_valid0 = 1'b1;
    tick();
    din_valid0 = 1'b0;
    din0       = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (sout0 !== exp_bits[7-i] || sout_valid0 !== 1'b1 ||
          frame_start0 !== (i == 0)) begin
        tests_failed++;
        $display("FAIL single_bit%0d: sout=%b sv=%b fs=%b expected %b 1 %b",
                 i, sout0, sout_valid0, frame_start0, exp_bits[7-i], (i == 0));
      end
      tick();
    end
    tests_run++;
    if (sout0 !== 1'b1 || sout_valid0 !== 1'b0 || word_cnt0 !== 16'd1) begin
      tests_failed++;
      $display("FAIL single_after: sout=%b sv=%b cnt=%h expected 1 0 0001",
               sout0, sout_valid0, word_cnt0);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_bits;
    int          fs_count;
    exp_bits = 16'hA53C;
    fs_count = 0;
    apply_reset();
    din0       = 8'hA5;
    din_valid0 = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      if (i == 0) din0 = 8'h3C;
      if (i == 1) din_valid0 = 1'b0;
      tests_run++;
      if (sout0 !== exp_bits[15-i] || sout_valid0 !== 1'b1 ||
          frame_start0 !== (i == 0 || i == 8)) begin
        tests_failed++;
        $display("FAIL b2b_bit%0d: sout=%b sv=%b fs=%b expected %b 1 %b",
                 i, sout0, sout_valid0, frame_start0, exp_bits[15-i], (i == 0 || i == 8));
      end
      tests_run++;
      if (din_ready0 !== !(i >= 1 && i <= 7)) begin
        tests_failed++;
        $display("FAIL b2b_ready%0d: rdy=%b expected %b", i, din_ready0, !(i >= 1 && i <= 7));
      end
      if (frame_start0 === 1'b1) fs_count++;
      tick();
    end
    tests_run++;
    if (fs_count != 2 || word_cnt0 !== 16'd2 || sout_valid0 !== 1'b0 || sout0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_after: pulses=%0d cnt=%h sv=%b sout=%b expected 2 0002 0 1",
               fs_count, word_cnt0, sout_valid0, sout0);
    end
  endtask

  task automatic test_direct_load();
    logic [15:0] exp_bits;
    exp_bits = 16'hA5C3;
    apply_reset();
    din0       = 8'hA5;
    din_valid0 = 1'b1;
    tick();
    din_valid0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      // Offer the second word only during the last bit of the first.
      if (i == 7) begin
        din0       = 8'hC3;
        din_valid0 = 1'b1;
      end
      if (i == 8) din_valid0 = 1'b0;
      tests_run++;
      if (sout0 !== exp_bits[15-i] || sout_valid0 !== 1'b1 ||
          frame_start0 !== (i == 0 || i == 8) || din_ready0 !== 1'b1) begin
        tests_failed++;
        $display("FAIL direct_bit%0d: sout=%b sv=%b fs=%b rdy=%b expected %b 1 %b 1",
                 i, sout0, sout_valid0, frame_start0, din_ready0, exp_bits[15-i],
                 (i == 0 || i == 8));
      end
      tick();
    end
    tests_run++;
    if (word_cnt0 !== 16'd2 || sout_valid0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL direct_after: cnt=%h sv=%b expected 0002 0", word_cnt0, sout_valid0);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] words [2];
    words[0] = 8'h01;
    words[1] = 8'hB2;
    apply_reset();
    for (int w = 0; w < 2; w++) begin
      din1       = words[w];
      din_valid1 = 1'b1;
      tick();
      din_valid1 = 1'b0;
      din1       = 8'h00;
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (sout1 !== words[w][i] || sout_valid1 !== 1'b1 || frame_start1 !== (i == 0)) begin
          tests_failed++;
          $display("FAIL lsb_w%0d_bit%0d: sout=%b sv=%b fs=%b expected %b 1 %b",
                   w, i, sout1, sout_valid1, frame_start1, words[w][i], (i == 0));
        end
        tick();
      end
    end
    tests_run++;
    if (word_cnt1 !== 16'd2 || sout1 !== 1'b1 || sout_valid1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL lsb_after: cnt=%h sout=%b sv=%b expected 0002 1 0",
               word_cnt1, sout1, sout_valid1);
    end
  endtask

  task automatic test_reset_mid_word();
    apply_reset();
    din0       = 8'hA5;
    din_valid0 = 1'b1;
    tick();
    din0 = 8'h3C;
    tick();
    din_valid0 = 1'b0;
    tick();
    tick();
    // Fourth bit of 0xA5 is on the line and the holding buffer is full.
    tests_run++;
    if (sout0 !== 1'b0 || din_ready0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_pre: sout=%b rdy=%b expected 0 0", sout0, din_ready0);
    end
    rst_n = 1'b0;
    tick();
    tests_run++;
    if (sout0 !== 1'b1 || sout_valid0 !== 1'b0 || word_cnt0 !== 16'h0000 ||
        frame_start0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_state: sout=%b sv=%b cnt=%h fs=%b expected 1 0 0000 0",
               sout0, sout_valid0, word_cnt0, frame_start0);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (din_ready0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_ready: rdy=%b expected 1", din_ready0);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (sout_valid0 !== 1'b0 || sout0 !== 1'b1 || word_cnt0 !== 16'h0000) begin
        tests_failed++;
        $display("FAIL midreset_idle%0d: sv=%b sout=%b cnt=%h expected 0 1 0000",
                 i, sout_valid0, sout0, word_cnt0);
      end
    end
  endtask

  task automatic test_word_cnt_wrap();
    apply_reset();
    force dut0.word_cnt_q = 16'hFFFF;
    tick();
    release dut0.word_cnt_q;
    tick();
    tests_run++;
    if (word_cnt0 !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL wrap_preload: cnt=%h expected ffff", word_cnt0);
    end
    din0       = 8'h4A;
    din_valid0 = 1'b1;
    tick();
    din_valid0 = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    tests_run++;
    if (word_cnt0 !== 16'h0000 || sout_valid0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_result: cnt=%h sv=%b expected 0000 0", word_cnt0, sout_valid0);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    din0         = 8'h00;
    din1         = 8'h00;
    din_valid0   = 1'b0;
    din_valid1   = 1'b0;
    #2;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_direct_load();
    test_lsb_first();
    test_reset_mid_word();
    test_word_cnt_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
